// File: rtl/knn_classifier_core.sv
// k-nearest-neighbour classifier: scans a loadable table of labelled 2-D points one per
// cycle, keeps a sorted nearest list, then majority-votes over the first k entries.
module knn_classifier_core #(
  parameter int DATA_W = 8,
  parameter int N_PTS  = 8,
  parameter int CLS_W  = 2,
  parameter int K_MAX  = 7,
  parameter int LAT_W  = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     tr_we_i,
  input  logic [$clog2(N_PTS)-1:0] tr_addr_i,
  input  logic [DATA_W-1:0]        tr_x_i,
  input  logic [DATA_W-1:0]        tr_y_i,
  input  logic [CLS_W-1:0]         tr_cls_i,
  input  logic                     start_i,
  input  logic [DATA_W-1:0]        x_in_i,
  input  logic [DATA_W-1:0]        y_in_i,
  input  logic [3:0]               k_sel_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [CLS_W-1:0]         pred_class_o,
  output logic [DATA_W+1:0]        min_dist_o,
  output logic                     tie_o,
  output logic [LAT_W-1:0]         latency_o
);
  localparam int AW = $clog2(N_PTS);
  localparam int DW = DATA_W + 2;
  localparam int NC = 2 ** CLS_W;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_VOTE = 2'd2} state_t;
  state_t state_q, state_d;

  logic [DATA_W-1:0] tab_x [N_PTS];
  logic [DATA_W-1:0] tab_y [N_PTS];
  logic [CLS_W-1:0]  tab_c [N_PTS];
  logic [N_PTS-1:0]  tab_v_q;

  logic [DATA_W-1:0] qx_q, qy_q;
  logic [3:0]        k_q, k_eff;
  logic [AW-1:0]     idx_q;
  logic [LAT_W-1:0]  cnt_q;

  logic [K_MAX-1:0]  lst_v_q, lst_v_d, gt;
  logic [DW-1:0]     lst_d_q [K_MAX];
  logic [DW-1:0]     lst_d_d [K_MAX];
  logic [CLS_W-1:0]  lst_c_q [K_MAX];
  logic [CLS_W-1:0]  lst_c_d [K_MAX];

  logic              done_q, tie_q;
  logic [CLS_W-1:0]  pred_q;
  logic [DW-1:0]     mind_q;
  logic [LAT_W-1:0]  lat_q;

  logic wr_en, start_acc, last_idx, cur_v;
  logic [DATA_W-1:0] cur_x, cur_y;
  logic [CLS_W-1:0]  cur_c;
  logic [DATA_W:0]   dx, dy, ax, ay;
  logic [DW-1:0]     cur_d;

  assign wr_en     = tr_we_i && !busy_o && (int'(tr_addr_i) < N_PTS);
  assign start_acc = (state_q == S_IDLE) && start_i;
  assign last_idx  = (idx_q == AW'(N_PTS - 1));

  always_comb begin
    if (k_sel_i == 4'd0)              k_eff = 4'd1;
    else if (k_sel_i > 4'(K_MAX))     k_eff = 4'(K_MAX);
    else                              k_eff = k_sel_i;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tab_x[tr_addr_i] <= tr_x_i;
      tab_y[tr_addr_i] <= tr_y_i;
      tab_c[tr_addr_i] <= tr_cls_i;
    end
  end

  assign cur_x = tab_x[idx_q];
  assign cur_y = tab_y[idx_q];
  assign cur_c = tab_c[idx_q];
  assign cur_v = tab_v_q[idx_q];

  // Sign-extend by one bit so the difference of any two coordinates fits.
  assign dx    = {qx_q[DATA_W-1], qx_q} - {cur_x[DATA_W-1], cur_x};
  assign dy    = {qy_q[DATA_W-1], qy_q} - {cur_y[DATA_W-1], cur_y};
  assign ax    = dx[DATA_W] ? ((DATA_W+1)'(0) - dx) : dx;
  assign ay    = dy[DATA_W] ? ((DATA_W+1)'(0) - dy) : dy;
  assign cur_d = {1'b0, ax} + {1'b0, ay};

  // Empty slots count as "greater", so gt is monotone and marks the insert point.
  for (genvar gi = 0; gi < K_MAX; gi++) begin : g_ins
    assign gt[gi] = !lst_v_q[gi] || (lst_d_q[gi] > cur_d);
    if (gi == 0) begin : g_head
      assign lst_d_d[gi] = gt[gi] ? cur_d : lst_d_q[gi];
      assign lst_c_d[gi] = gt[gi] ? cur_c : lst_c_q[gi];
      assign lst_v_d[gi] = gt[gi] ? 1'b1  : lst_v_q[gi];
    end else begin : g_tail
      assign lst_d_d[gi] = gt[gi-1] ? lst_d_q[gi-1] : (gt[gi] ? cur_d : lst_d_q[gi]);
      assign lst_c_d[gi] = gt[gi-1] ? lst_c_q[gi-1] : (gt[gi] ? cur_c : lst_c_q[gi]);
      assign lst_v_d[gi] = gt[gi-1] ? lst_v_q[gi-1] : (gt[gi] ? 1'b1  : lst_v_q[gi]);
    end
  end

  logic [3:0]       cls_cnt [NC];
  logic [3:0]       top_cnt, n_top;
  logic [CLS_W-1:0] win_cls;
  logic             win_tie;

  always_comb begin
    for (int c = 0; c < NC; c++) cls_cnt[c] = '0;
    top_cnt = '0;
    n_top   = '0;
    win_cls = '0;
    for (int p = 0; p < K_MAX; p++)
      if (lst_v_q[p] && (4'(p) < k_q)) cls_cnt[lst_c_q[p]] = cls_cnt[lst_c_q[p]] + 4'd1;
    for (int c = 0; c < NC; c++)
      if (cls_cnt[c] > top_cnt) top_cnt = cls_cnt[c];
    for (int c = 0; c < NC; c++)
      if (cls_cnt[c] == top_cnt) n_top = n_top + 4'd1;
    // Walk from the far end so the nearest top-count class is left standing.
    for (int p = K_MAX - 1; p >= 0; p--)
      if (lst_v_q[p] && (4'(p) < k_q) && (cls_cnt[lst_c_q[p]] == top_cnt)) win_cls = lst_c_q[p];
    win_tie = lst_v_q[0] && (n_top > 4'd1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_SCAN;
      S_SCAN:  if (last_idx) state_d = S_VOTE;
      S_VOTE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tab_v_q <= '0;
      lst_v_q <= '0;
      qx_q    <= '0;
      qy_q    <= '0;
      k_q     <= 4'd1;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      tie_q   <= 1'b0;
      pred_q  <= '0;
      mind_q  <= '0;
      lat_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (wr_en) tab_v_q[tr_addr_i] <= 1'b1;
      if (start_acc) begin
        qx_q    <= x_in_i;
        qy_q    <= y_in_i;
        k_q     <= k_eff;
        lst_v_q <= '0;
        idx_q   <= '0;
        cnt_q   <= '0;
      end
      if (state_q == S_SCAN) begin
        idx_q <= idx_q + AW'(1);
        cnt_q <= cnt_q + LAT_W'(1);
        if (cur_v) lst_v_q <= lst_v_d;
      end
      if (state_q == S_VOTE) begin
        pred_q <= win_cls;
        tie_q  <= win_tie;
        mind_q <= lst_v_q[0] ? lst_d_q[0] : '1;
        lat_q  <= cnt_q + LAT_W'(1);
        done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if ((state_q == S_SCAN) && cur_v) begin
      for (int p = 0; p < K_MAX; p++) begin
        lst_d_q[p] <= lst_d_d[p];
        lst_c_q[p] <= lst_c_d[p];
      end
    end
  end

  assign done_o       = done_q;
  assign pred_class_o = pred_q;
  assign min_dist_o   = mind_q;
  assign tie_o        = tie_q;
  assign latency_o    = lat_q;
endmodule

// File: tb/tb_knn_classifier_core.sv
// Bench for knn_classifier_core: directed and random queries checked against a
// reference model via an expected-result queue drained by a done-driven monitor.
module tb_knn_classifier_core;
  localparam int DATA_W = 8;
  localparam int N_PTS  = 8;
  localparam int CLS_W  = 2;
  localparam int K_MAX  = 7;
  localparam int LAT_W  = 16;
  localparam int NC     = 4;
  localparam int AW     = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              tr_we = 1'b0;
  logic [AW-1:0]     tr_addr = '0;
  logic [DATA_W-1:0] tr_x = '0, tr_y = '0;
  logic [CLS_W-1:0]  tr_cls = '0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] x_in = '0, y_in = '0;
  logic [3:0]        k_sel = '0;
  logic              busy, done, tie;
  logic [CLS_W-1:0]  pred_class;
  logic [DATA_W+1:0] min_dist;
  logic [LAT_W-1:0]  latency;

  knn_classifier_core #(
    .DATA_W(DATA_W), .N_PTS(N_PTS), .CLS_W(CLS_W), .K_MAX(K_MAX), .LAT_W(LAT_W)
  ) dut (
    .clk_i(clk), .reset_i(reset), .tr_we_i(tr_we), .tr_addr_i(tr_addr),
    .tr_x_i(tr_x), .tr_y_i(tr_y), .tr_cls_i(tr_cls), .start_i(start),
    .x_in_i(x_in), .y_in_i(y_in), .k_sel_i(k_sel), .busy_o(busy), .done_o(done),
    .pred_class_o(pred_class), .min_dist_o(min_dist), .tie_o(tie), .latency_o(latency)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int pred;
    int mind;
    int tie;
    int lat;
    int cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_mon;

  int n_vec = 0;
  int n_bad = 0;
  int n_txn = 0;

  int m_x [N_PTS];
  int m_y [N_PTS];
  int m_c [N_PTS];
  bit m_v [N_PTS];

  task automatic chk(input string nm, input int act, input int ex);
    n_vec++;
    if (act != ex) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, ex, cyc);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: rank valid points by (distance, index), keep K_MAX, majority vote.
  function automatic void model(input int qx, input int qy, input int ks,
                                output int pred, output int mind, output int tie_r);
    int ke, best, top, ntop;
    int d [N_PTS];
    bit used [N_PTS];
    int cnt [NC];
    int oc[$];
    int od[$];
    ke = (ks == 0) ? 1 : ((ks > K_MAX) ? K_MAX : ks);
    for (int i = 0; i < N_PTS; i++) begin
      d[i] = iabs(qx - m_x[i]) + iabs(qy - m_y[i]);
      used[i] = 1'b0;
    end
    for (int r = 0; r < K_MAX; r++) begin
      best = -1;
      for (int i = 0; i < N_PTS; i++)
        if (m_v[i] && !used[i]) begin
          if (best < 0) best = i;
          else if (d[i] < d[best]) best = i;
        end
      if (best >= 0) begin
        used[best] = 1'b1;
        oc.push_back(m_c[best]);
        od.push_back(d[best]);
      end
    end
    for (int c = 0; c < NC; c++) cnt[c] = 0;
    for (int p = 0; p < ke && p < oc.size(); p++) cnt[oc[p]]++;
    top = 0;
    for (int c = 0; c < NC; c++) if (cnt[c] > top) top = cnt[c];
    ntop = 0;
    for (int c = 0; c < NC; c++) if (cnt[c] == top) ntop++;
    pred = 0;
    tie_r = 0;
    mind = (1 << (DATA_W + 2)) - 1;
    if (oc.size() > 0) begin
      mind = od[0];
      tie_r = (ntop > 1) ? 1 : 0;
      for (int p = 0; p < ke && p < oc.size(); p++)
        if (cnt[oc[p]] == top) begin
          pred = oc[p];
          break;
        end
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, expected done=0 (cycle %0d)", cyc);
      end else begin
        e_mon = exp_q.pop_front();
        n_txn++;
        chk("pred_class", int'(pred_class), e_mon.pred);
        chk("min_dist", int'(min_dist), e_mon.mind);
        chk("tie", int'(tie), e_mon.tie);
        chk("latency", int'(latency), e_mon.lat);
        chk("done_cycle", cyc, e_mon.cyc);
        chk("busy_at_done", int'(busy), 0);
        $display("txn %0d: pred=%0d min_dist=%0d tie=%0d latency=%0d cycle=%0d", n_txn,
                 pred_class, min_dist, tie, latency, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int x, input int y, input int c, input bit upd);
    tr_we   = 1'b1;
    tr_addr = AW'(a);
    tr_x    = DATA_W'(x);
    tr_y    = DATA_W'(y);
    tr_cls  = CLS_W'(c);
    tick();
    tr_we   = 1'b0;
    if (upd) begin
      m_x[a] = x;
      m_y[a] = y;
      m_c[a] = c;
      m_v[a] = 1'b1;
    end
  endtask

  task automatic issue(input int qx, input int qy, input int ks);
    exp_t e;
    model(qx, qy, ks, e.pred, e.mind, e.tie);
    x_in  = DATA_W'(qx);
    y_in  = DATA_W'(qy);
    k_sel = 4'(ks);
    start = 1'b1;
    tick();
    start = 1'b0;
    e.lat = N_PTS + 1;
    e.cyc = cyc + N_PTS + 1;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 60) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got %0d results pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_done: got done=0, expected done=1 within 40 cycles");
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N_PTS; i++) m_v[i] = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic load5();
    wr(0, 0, 0, 0, 1'b1);
    wr(1, 3, 0, 1, 1'b1);
    wr(2, 0, 4, 1, 1'b1);
    wr(3, -2, 0, 0, 1'b1);
    wr(4, 100, 100, 2, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ks_list [6];
    for (int i = 0; i < N_PTS; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_c[i] = 0; m_v[i] = 1'b0;
    end
    #1 reset = 1'b1;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pred", int'(pred_class), 0);
    chk("rst_min_dist", int'(min_dist), 0);
    chk("rst_tie", int'(tie), 0);
    chk("rst_latency", int'(latency), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Directed: sorted distances from (1,0) are 1,2,3,5,199.
    load5();
    ks_list = '{1, 2, 3, 5, 7, 0};
    for (int i = 0; i < 6; i++) begin
      issue(1, 0, ks_list[i]);
      drain();
    end
    issue(1, 0, 15);
    drain();

    // Extreme coordinates, then an empty table.
    do_reset();
    wr(0, -128, -128, 3, 1'b1);
    issue(127, 127, 1);
    drain();
    do_reset();
    issue(5, -7, 3);
    drain();

    // Start and write while busy must be ignored.
    do_reset();
    load5();
    issue(1, 0, 2);
    chk("busy_in_scan", int'(busy), 1);
    tick();
    start = 1'b1;
    x_in  = DATA_W'(50);
    wr(1, 1, 0, 2, 1'b0);
    start = 1'b0;
    drain();
    issue(1, 0, 2);
    drain();

    // Back-to-back: start held in the done cycle.
    issue(1, 0, 3);
    wait_done();
    issue(-2, 0, 5);
    drain();

    // Reset mid-scan aborts without a done pulse and clears valid bits.
    issue(1, 0, 3);
    repeat (4) tick();
    reset = 1'b1;
    clear_model();
    #1;
    chk("busy_after_abort", int'(busy), 0);
    chk("done_after_abort", int'(done), 0);
    tick();
    reset = 1'b0;
    repeat (15) tick();
    issue(1, 0, 1);
    drain();
    load5();
    issue(1, 0, 3);
    drain();

    // Randomized table updates and queries.
    for (int r = 0; r < 40; r++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++)
        wr($urandom_range(0, N_PTS - 1), int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128, $urandom_range(0, NC - 1), 1'b1);
      issue(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
            $urandom_range(0, 15));
      if ((r % 4) == 3) begin
        wait_done();
        issue(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
              $urandom_range(0, 15));
      end
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
